out_pixel_writer: RTL
=====================

# out_pixel_writer

Upstream feeder for the output pixel memory. Accepts 32-bit datapath results through a valid/ready handshake and buffers them in a small FIFO. Converts each result to an 8-bit pixel and drains the pixels as sequential write beats, with incrementing addresses, into the output memory. Counts one frame of `PIXEL_COUNT` pixels, raises a done flag when the frame is written, then holds until cleared.

## Interface
Parameters:
- `PIXEL_COUNT`, 10: pixels per frame.
- `ADDR_W`, 4: output address width; must satisfy 2^ADDR_W ≥ PIXEL_COUNT.
- `FIFO_DEPTH`, 4: buffer entries; power of two, ≥ 2.

Ports:
- One clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `result_i` in 32: datapath result, signed two's complement.
- `result_valid_i` in 1: `result_i` is valid this cycle.
- `result_ready_o` out 1: block accepts `result_i` this cycle.
- `mem_we_o` out 1: write beat is presented.
- `mem_addr_o` out ADDR_W: pixel address of the current beat.
- `mem_data_o` out 8: pixel value of the current beat.
- `mem_ready_i` in 1: output memory accepts the beat.
- `frame_done_o` out 1: all `PIXEL_COUNT` pixels are written.
- `frame_clear_i` in 1: start a new frame (acts only in DONE).

## Operation
- **Accept**
  - A result is accepted on a rising edge with `result_valid_i && result_ready_o`.
  - `result_ready_o = !fifo_full && (accept_cnt < PIXEL_COUNT) && state != DONE`.
  - `result_ready_o` is computed from registered state only.
- **Pixel conversion:** applied on entry to the FIFO; see Configuration.
- **FIFO:** `FIFO_DEPTH` entries of 8 bits; first in, first out; pointers wrap at `FIFO_DEPTH`.
- **States:**
  - IDLE: FIFO empty, `mem_we_o = 0`. Go to DRAIN on the first accept.
  - DRAIN: `mem_we_o = !fifo_empty`; `mem_data_o` = FIFO head; `mem_addr_o` = `wr_cnt`.
    - A beat completes when `mem_we_o && mem_ready_i`: pop the head, `wr_cnt++`.
    - On the completion with `wr_cnt == PIXEL_COUNT-1`, go to DONE.
  - DONE: `frame_done_o = 1`, `mem_we_o = 0`, `result_ready_o = 0`.
    - On `frame_clear_i`, go to IDLE with `wr_cnt = 0` and `accept_cnt = 0`.
- **Handshake stability:** while `mem_we_o = 1` and `mem_ready_i = 0`, `mem_addr_o` and `mem_data_o` hold stable.
- **Ignored inputs:**
  - `frame_clear_i` outside DONE is ignored.
  - `result_valid_i` while `result_ready_o = 0` is ignored; there is no drop counter.
- **Counters:**
  - `accept_cnt` and `wr_cnt` are ceil(log2(PIXEL_COUNT+1)) bits wide.
  - Neither counter exceeds `PIXEL_COUNT`.
  - `mem_addr_o` is `wr_cnt` truncated to ADDR_W.

## Timing
- **Reset values:** `result_ready_o = 1`, `mem_we_o = 0`, `mem_addr_o = 0`, `mem_data_o = 0`, `frame_done_o = 0`. State is IDLE, FIFO is empty, both counters are 0.
- **Latency:** a result accepted at edge N with the FIFO empty drives `mem_we_o = 1` with its pixel in cycle N+1.
- **Throughput:** one pixel per cycle sustained when `mem_ready_i = 1`.
- **Push and pop in the same edge:**
  - Allowed when the FIFO is non-empty; the occupancy count is unchanged.
  - On an empty FIFO, only the push takes effect; a pop requires prior occupancy.
- **Full FIFO:** `result_ready_o = 0` even if a pop occurs that edge. Ready re-asserts the cycle after the pop.
- **Last pixel:** `frame_done_o` rises in the cycle after the last beat's completing edge.
- **Clear:** `frame_done_o` falls the cycle after the `frame_clear_i` edge. `result_ready_o` returns to 1 that same cycle.
- **Mid-operation reset:** `rst` asserted at any time discards FIFO contents and counters. All outputs go to their reset values asynchronously, with no glitch-free requirement on `mem_we_o`.

## Configuration
- Macro: `OUT_PIXEL_SAT_EN`.
- **Defined:** saturating conversion.
  - `result_i < 0` gives pixel 0.
  - `result_i > 255` gives pixel 255.
  - Otherwise pixel = `result_i[7:0]`.
- **Undefined:** pixel = `result_i[7:0]` (plain truncation); the comparators are not built.

## Test plan
- **Reset, then stream:** reset, then 10 back-to-back results 0..9 with `mem_ready_i = 1` → writes to addresses 0..9 with data 0..9. First `mem_we_o` one cycle after the first accept. `frame_done_o` = 1 after beat 9.
- **Backpressure:** hold `mem_ready_i = 0` while sending 6 results.
  - `result_ready_o` drops after 4 accepts, and addr 0 / data stays stable.
  - Release `mem_ready_i` → all 6 written in order, and ready re-asserts the cycle after the first pop.
- **Saturation:** send −5, 300, 128, 0x0000_01FF.
  - With `OUT_PIXEL_SAT_EN` → 0, 255, 128, 255.
  - Without the macro → 0xFB, 0x2C, 0x80, 0xFF.
- **Overrun:** offer 12 results → exactly 10 are accepted. `result_ready_o = 0` in DONE. `frame_clear_i` → ready = 1 and the next write goes to addr 0.
- **Reset mid-frame:** assert `rst` after 3 writes with 2 entries buffered → `mem_we_o = 0` immediately. The next frame starts at addr 0 with no stale data written.
- **Spurious clear:** pulse `frame_clear_i` in DRAIN at addr 4 → no effect; writes continue at 5..9 and `frame_done_o` rises.

Source files
------------

// File: rtl/out_pixel_writer.sv
// out_pixel_writer: buffers 32-bit results in a small FIFO, converts them to 8-bit pixels and
// writes one frame of PIXEL_COUNT pixels to the output memory. Define OUT_PIXEL_SAT_EN for saturating conversion.
module out_pixel_writer #(
    parameter int PIXEL_COUNT = 10,
    parameter int ADDR_W      = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       result_i,
    input  logic              result_valid_i,
    output logic              result_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_data_o,
    input  logic              mem_ready_i,
    output logic              frame_done_o,
    input  logic              frame_clear_i
);
    localparam int CNT_W = $clog2(PIXEL_COUNT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PIXEL_COUNT - 1);
    localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(PIXEL_COUNT);
    localparam logic [PTR_W:0]   FULL_LVL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             fifo_full, fifo_empty;
    logic             push, pop, last_beat;
    logic [7:0]       pixel;

    assign fifo_full  = (level_q == FULL_LVL);
    assign fifo_empty = (level_q == '0);
    assign push       = result_valid_i && result_ready_o;
    assign pop        = mem_we_o && mem_ready_i;
    assign last_beat  = pop && (wr_cnt_q == LAST_IDX);

`ifdef OUT_PIXEL_SAT_EN
    always_comb begin
        if (result_i[31]) begin
            pixel = 8'h00;
        end else if (|result_i[30:8]) begin
            pixel = 8'hFF;
        end else begin
            pixel = result_i[7:0];
        end
    end
`else
    logic unused_upper;
    assign pixel        = result_i[7:0];
    assign unused_upper = ^result_i[31:8];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (push) state_d = DRAIN;
            DRAIN:   if (last_beat) state_d = DONE;
            DONE:    if (frame_clear_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_ready_o = !fifo_full && (accept_cnt_q < FRAME_LEN) && (state_q != DONE);
        mem_we_o       = (state_q == DRAIN) && !fifo_empty;
        mem_data_o     = ((state_q == DRAIN) && !fifo_empty) ? fifo_mem[rd_ptr_q] : 8'h00;
        frame_done_o   = (state_q == DONE);
    end

    if (CNT_W >= ADDR_W) begin : g_addr_trunc
        assign mem_addr_o = wr_cnt_q[ADDR_W-1:0];
    end else begin : g_addr_ext
        assign mem_addr_o = {{(ADDR_W - CNT_W){1'b0}}, wr_cnt_q};
    end

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        accept_cnt_d = accept_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        if (push) begin
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            accept_cnt_d = accept_cnt_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + (PTR_W + 1)'(1);
            2'b01:   level_d = level_q - (PTR_W + 1)'(1);
            default: level_d = level_q;
        endcase
        if ((state_q == DONE) && frame_clear_i) begin
            accept_cnt_d = '0;
            wr_cnt_d     = '0;
        end
    end

    // NOTE: nonblocking assignments for all state; the blocking form would race other clocked readers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            accept_cnt_q <= '0;
            wr_cnt_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            accept_cnt_q <= accept_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    // NOTE: storage is not reset; clearing the pointers and level already discards the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= pixel;
        end
    end

endmodule
